// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite row blitter.
// Optional build macro used by the blitter: SPRITE_TRANSPARENCY_EN.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PIX_W           = 4;
  localparam int SHEET_W         = 512;
  localparam int SHEET_XW        = $clog2(SHEET_W);
  localparam int TRANSPARENT_IDX = 0;
  localparam int PIX_PER_WORD    = 4;

endpackage

// File: rtl/sprite_row_blitter_pixel_merge.sv
// Combinational merge of four freshly fetched pixels over an old line-buffer word.
// With TRANSP_EN set, pixels equal to the transparent index keep the old nibble.
module pixel_merge #(
  parameter int PIX_W     = sprite_pkg::PIX_W,
  parameter bit TRANSP_EN = 1'b0
) (
  input  logic [4*PIX_W-1:0] new_pixels,
  input  logic [4*PIX_W-1:0] old_word,
  output logic [4*PIX_W-1:0] merged
);
  import sprite_pkg::*;

  always_comb begin
    merged = new_pixels;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (TRANSP_EN && (new_pixels[i*PIX_W +: PIX_W] == PIX_W'(TRANSPARENT_IDX))) begin
        merged[i*PIX_W +: PIX_W] = old_word[i*PIX_W +: PIX_W];
      end
    end
  end

endmodule

// File: rtl/sprite_row_blitter.sv
// Copies one sprite row from a spritesheet ROM into a packed line buffer, 5 cycles per word.
// Define SPRITE_TRANSPARENCY_EN to read-modify-write so pixel value 0 leaves the buffer untouched.
module sprite_row_blitter #(
  parameter int PIX_W    = sprite_pkg::PIX_W,
  parameter int SPRITE_W = 16,
  parameter int SHEET_AW = 18,
  parameter int ROW_AW   = 8
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8:0]            req_sheet_x,
  input  logic [8:0]            req_sheet_y,
  input  logic [ROW_AW-1:0]     req_word_x,
  output logic [SHEET_AW-1:0]   sheet_addr,
  input  logic [PIX_W-1:0]      sheet_data,
  output logic [ROW_AW-1:0]     row_rd_addr,
  input  logic [4*PIX_W-1:0]    row_rd_data,
  output logic                  row_we,
  output logic [ROW_AW-1:0]     row_wr_addr,
  output logic [4*PIX_W-1:0]    row_wr_data,
  output logic                  busy,
  output logic                  done,
  output sprite_pkg::state_t    fsm_state
);
  import sprite_pkg::*;

  localparam int WORDS = SPRITE_W / PIX_PER_WORD;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WW-1:0] LAST_W = WW'(WORDS - 1);

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so requests arriving while busy simply wait.
  state_t                state_q, state_d;
  logic [WW-1:0]         w_q, w_d;
  logic [1:0]            k_q, k_d;
  logic [8:0]            x_q, y_q;
  logic [ROW_AW-1:0]     word_x_q;
  logic [3*PIX_W-1:0]    pix_q;
  logic [4*PIX_W-1:0]    new_word;
  logic [4*PIX_W-1:0]    merged_word;
  logic [8:0]            x_cur;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      w_q      <= '0;
      k_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      word_x_q <= '0;
      pix_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      k_q     <= k_d;
      if (req_valid && req_ready) begin
        x_q      <= req_sheet_x;
        y_q      <= req_sheet_y;
        word_x_q <= req_word_x;
      end
      // ROM data lags the address by one cycle, so pixel k-1 lands while k is addressed.
      if (state_q == ST_FETCH) begin
        case (k_q)
          2'd1:    pix_q[PIX_W-1:0]         <= sheet_data;
          2'd2:    pix_q[2*PIX_W-1:PIX_W]   <= sheet_data;
          2'd3:    pix_q[3*PIX_W-1:2*PIX_W] <= sheet_data;
          default: pix_q                    <= pix_q;
        endcase
      end
    end
  end

  assign x_cur    = x_q + 9'({w_q, k_q});
  assign new_word = {sheet_data, pix_q};

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    k_d         = k_q;
    req_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    row_we      = 1'b0;
    sheet_addr  = '0;
    row_wr_addr = '0;
    row_wr_data = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_d = ST_FETCH;
          w_d     = '0;
          k_d     = '0;
        end
      end
      ST_FETCH: begin
        sheet_addr = SHEET_AW'({y_q, x_cur});
        k_d        = k_q + 2'd1;
        if (k_q == 2'd3) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        row_we      = 1'b1;
        row_wr_addr = word_x_q + ROW_AW'(w_q);
        row_wr_data = merged_word;
        k_d         = '0;
        if (w_q == LAST_W) begin
          state_d = ST_DONE;
        end else begin
          w_d     = w_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        w_d     = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SPRITE_TRANSPARENCY_EN
  // Held through FETCH so the old word is valid in the WRITE cycle.
  assign row_rd_addr = (state_q == ST_FETCH) ? (word_x_q + ROW_AW'(w_q)) : '0;
`else
  assign row_rd_addr = '0;
`endif

  pixel_merge #(
    .PIX_W     (PIX_W),
    .TRANSP_EN (TRANSP_EN)
  ) u_pixel_merge (
    .new_pixels (new_word),
    .old_word   (row_rd_data),
    .merged     (merged_word)
  );

  assign fsm_state = state_q;

endmodule

// File: tb/tb_sprite_row_blitter.sv
// Self-checking bench for sprite_row_blitter: ROM and line-buffer models, expected-write scoreboard,
// per-cycle timing checks relative to request acceptance.
module tb_sprite_row_blitter;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_sheet_x, req_sheet_y;
  logic [7:0]  req_word_x;
  logic [17:0] sheet_addr;
  logic [3:0]  sheet_data = '0;
  logic [7:0]  row_rd_addr;
  logic [15:0] row_rd_data = '0;
  logic        row_we;
  logic [7:0]  row_wr_addr;
  logic [15:0] row_wr_data;
  logic        busy, done;
  state_t      fsm_state;

  always #5 clk = ~clk;

  sprite_row_blitter dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sheet_x (req_sheet_x),
    .req_sheet_y (req_sheet_y),
    .req_word_x  (req_word_x),
    .sheet_addr  (sheet_addr),
    .sheet_data  (sheet_data),
    .row_rd_addr (row_rd_addr),
    .row_rd_data (row_rd_data),
    .row_we      (row_we),
    .row_wr_addr (row_wr_addr),
    .row_wr_data (row_wr_data),
    .busy        (busy),
    .done        (done),
    .fsm_state   (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Spritesheet content: row 3 counts 1..F, row 5 is the 0,5,0,7 transparency pattern.
  function automatic logic [3:0] rom_fn(input logic [17:0] a);
    int x, y;
    x = int'(a[8:0]);
    y = int'(a[17:9]);
    if (y == 3) return 4'((x + 5) % 15 + 1);
    if (y == 5) begin
      case (x % 4)
        1:       return 4'd5;
        3:       return 4'd7;
        default: return 4'd0;
      endcase
    end
    return 4'((x * 5 + y * 3 + 1) % 16);
  endfunction

  logic [15:0] row_mem [256];
  logic [15:0] shadow  [256];

  always @(posedge clk) begin
    if (row_we) row_mem[row_wr_addr] <= row_wr_data;
    row_rd_data <= row_mem[row_rd_addr];
    sheet_data  <= rom_fn(sheet_addr);
  end

  initial begin
    for (int i = 0; i < 256; i++) row_mem[i] <= 16'hAAAA;
  end

  logic [23:0] exp_q[$];
  logic [17:0] sheet_q[$];

  function automatic logic [15:0] model_word(input int x, input int y, input int w);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) r[k*4 +: 4] = rom_fn({9'(y), 9'((x + 4*w + k) % 512)});
    return r;
  endfunction

  task automatic push_blit(input int x, input int y, input int wx, input bit use_tab, input logic [63:0] tab);
    for (int w = 0; w < 4; w++) begin
      int addr;
      logic [15:0] data;
      addr = (wx + w) % 256;
      data = use_tab ? tab[w*16 +: 16] : model_word(x, y, w);
`ifdef SPRITE_TRANSPARENCY_EN
      if (!use_tab) begin
        for (int k = 0; k < 4; k++)
          if (data[k*4 +: 4] == 4'd0) data[k*4 +: 4] = shadow[addr][k*4 +: 4];
      end
`endif
      shadow[addr] = data;
      exp_q.push_back({8'(addr), data});
      for (int k = 0; k < 4; k++) sheet_q.push_back({9'(y), 9'((x + 4*w + k) % 512)});
    end
  endtask

  // Bench-side view of the blit in flight, keyed to the acceptance edge.
  bit active = 1'b0;
  int acc_cyc = 0, prev_acc_cyc = 0, acc_cnt = 0;
  int done_cyc = 0, prev_done_cyc = 0, done_cnt = 0;
  int wr_cnt = 0;
  int cur_wx = 0;

  always @(negedge clk) begin : mon
    int rel;
    bit acc_now;
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_row_we", row_we, 0);
      check("rst_sheet_addr", sheet_addr, 0);
      check("rst_row_rd_addr", row_rd_addr, 0);
      check("rst_row_wr_addr", row_wr_addr, 0);
      check("rst_row_wr_data", row_wr_data, 0);
      check("rst_state", fsm_state, ST_IDLE);
      active = 1'b0;
      exp_q.delete();
      sheet_q.delete();
    end else begin
      rel     = active ? (cyc - acc_cyc + 1) : 0;
      acc_now = req_valid && !active;
      check("busy", busy, active);
      check("req_ready", req_ready, !active);
      check("done", done, active && rel == 21);
      check("row_we", row_we, active && rel > 0 && rel <= 20 && rel % 5 == 0);
      if (active && rel <= 20 && rel % 5 != 0) begin
        if (sheet_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sheet_addr: got 0x%0h with no address expected (cycle %0d)", sheet_addr, cyc);
        end else begin
          check("sheet_addr", sheet_addr, sheet_q.pop_front());
        end
`ifdef SPRITE_TRANSPARENCY_EN
        check("row_rd_addr", row_rd_addr, (cur_wx + (rel - 1) / 5) % 256);
`endif
      end
`ifndef SPRITE_TRANSPARENCY_EN
      check("row_rd_addr_zero", row_rd_addr, 0);
`endif
      if (row_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL row_write: got addr 0x%0h data 0x%0h with no write expected (cycle %0d)",
                   row_wr_addr, row_wr_data, cyc);
        end else begin
          check("row_write", {row_wr_addr, row_wr_data}, exp_q.pop_front());
        end
      end
      if (done) begin
        prev_done_cyc = done_cyc;
        done_cyc      = cyc;
        done_cnt++;
      end
      if (active && rel == 21) active = 1'b0;
      if (acc_now) begin
        active       = 1'b1;
        prev_acc_cyc = acc_cyc;
        acc_cyc      = cyc + 1;
        cur_wx       = int'(req_word_x);
        acc_cnt++;
      end
    end
  end

  task automatic wait_acc(input int target);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (acc_cnt >= target) return;
    end
    check("accept_timeout", acc_cnt, target);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= target) return;
    end
    check("done_timeout", done_cnt, target);
  endtask

  task automatic drive_req(input int x, input int y, input int wx);
    req_sheet_x = 9'(x);
    req_sheet_y = 9'(y);
    req_word_x  = 8'(wx);
    req_valid   = 1'b1;
  endtask

  task automatic run_blit(input int x, input int y, input int wx, input bit use_tab, input logic [63:0] tab);
    int a0, d0, w0;
    a0 = acc_cnt; d0 = done_cnt; w0 = wr_cnt;
    push_blit(x, y, wx, use_tab, tab);
    drive_req(x, y, wx);
    wait_acc(a0 + 1);
    req_valid = 1'b0;
    wait_done(d0 + 1);
    check("blit_write_count", wr_cnt - w0, 4);
    check("done_latency", done_cyc - acc_cyc + 1, 21);
  endtask

  typedef struct {
    int          x;
    int          y;
    int          wx;
    logic [63:0] words;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int a0, d0, w0, first_acc;
    for (int i = 0; i < 256; i++) shadow[i] = 16'hAAAA;
    vecs[0] = '{10,  3, 'h20, 64'h1FED_CBA9_8765_4321};
    vecs[1] = '{510, 3, 'hFE, 64'h4321_FEDC_BA98_7676};
`ifdef SPRITE_TRANSPARENCY_EN
    vecs[2] = '{0,   5, 'h40, {4{16'h7A5A}}};
`else
    vecs[2] = '{0,   5, 'h40, {4{16'h7050}}};
`endif

    rst_n = 1'b1; req_valid = 1'b0;
    req_sheet_x = '0; req_sheet_y = '0; req_word_x = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) run_blit(vecs[i].x, vecs[i].y, vecs[i].wx, 1'b1, vecs[i].words);

    for (int i = 0; i < 3; i++)
      run_blit($urandom_range(0, 511), $urandom_range(10, 200), 'h60 + i * 8, 1'b0, '0);

    // Second request raised mid-blit must wait for IDLE.
    a0 = acc_cnt; d0 = done_cnt; w0 = wr_cnt;
    push_blit(20, 12, 'h80, 1'b0, '0);
    drive_req(20, 12, 'h80);
    wait_acc(a0 + 1);
    req_valid = 1'b0;
    first_acc = acc_cyc;
    repeat (6) @(posedge clk);
    #1;
    push_blit(40, 13, 'h88, 1'b0, '0);
    drive_req(40, 13, 'h88);
    wait_acc(a0 + 2);
    req_valid = 1'b0;
    check("busy_accept_cycle", acc_cyc - first_acc, 22);
    wait_done(d0 + 2);
    check("busy_write_count", wr_cnt - w0, 8);

    // req_valid held: two blits back to back.
    a0 = acc_cnt; d0 = done_cnt; w0 = wr_cnt;
    push_blit(300, 20, 'h90, 1'b0, '0);
    push_blit(300, 20, 'h90, 1'b0, '0);
    drive_req(300, 20, 'h90);
    wait_acc(a0 + 2);
    req_valid = 1'b0;
    wait_done(d0 + 2);
    check("b2b_accept_gap", acc_cyc - prev_acc_cyc, 22);
    check("b2b_first_done", prev_done_cyc - prev_acc_cyc + 1, 21);
    check("b2b_second_done", done_cyc - prev_acc_cyc + 1, 43);
    check("b2b_write_count", wr_cnt - w0, 8);

    // Reset asserted in cycle 12 of a blit.
    a0 = acc_cnt; d0 = done_cnt; w0 = wr_cnt;
    push_blit(7, 30, 'hA0, 1'b0, '0);
    drive_req(7, 30, 'hA0);
    wait_acc(a0 + 1);
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #2 check("reset_ready_immediate", req_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("reset_write_count", wr_cnt - w0, 2);
    check("reset_no_done", done_cnt - d0, 0);
    check("reset_ready_after", req_ready, 1);

    run_blit(33, 3, 'hC0, 1'b0, '0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_row_blitter.md
SPRITE_ROW_BLITTER -- requirements
Module: sprite_row_blitter

Interface
REQ-001 SHALL have parameters: PIX_W, default 4, bits per pixel.
REQ-002 SHALL have parameter SPRITE_W, default 16, pixels per sprite row (multiple of 4).
REQ-003 SHALL have parameter SHEET_AW, default 18, spritesheet ROM address width ({y[8:0],x[8:0]}).
REQ-004 SHALL have parameter ROW_AW, default 8, line-buffer word address width.
REQ-005 SHALL have ports: Clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have Reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have req_valid  in  1  and req_ready  out  1, blit request handshake.
REQ-008 SHALL have req_sheet_x  in  9, req_sheet_y  in  9, and req_word_x  in  ROW_AW; these are the sprite-row source pixel and the destination word.
REQ-009 SHALL have sheet_addr  out  SHEET_AW and sheet_data  in  PIX_W; sheet_data is valid one cycle after sheet_addr.
REQ-010 SHALL have row_rd_addr  out  ROW_AW and row_rd_data  in  4*PIX_W; row_rd_data is valid one cycle after row_rd_addr.
REQ-011 SHALL have row_we  out  1, row_wr_addr  out  ROW_AW, and row_wr_data  out  4*PIX_W, the line-buffer write port.
REQ-012 SHALL have busy  out  1 (not IDLE) and done  out  1 (one-cycle completion pulse).

Function
REQ-013 SHALL implement states IDLE, FETCH, WRITE, DONE.
REQ-014 SHALL assert req_ready only in IDLE; a request is accepted on the edge where req_valid&&req_ready; it then latches x/y/word_x and enters FETCH with word index w=0 and pixel index k=0.
REQ-015 SHALL, in FETCH, drive sheet_addr={y, (x+4w+k) mod 512} for k=0..3 on 4 consecutive cycles, then go to WRITE.
REQ-016 SHALL capture the pixel for index k from sheet_data in the cycle after its address is driven; pixel 3 is taken live in WRITE.
REQ-017 SHALL pack pixel k into row_wr_data[PIX_W*k+PIX_W-1 : PIX_W*k].
REQ-018 SHALL, in WRITE, assert row_we for exactly one cycle with row_wr_addr=(word_x+w) mod 2^ROW_AW, so writes wrap around the line buffer.
REQ-019 SHALL, after WRITE, return to FETCH with w+1 if w<SPRITE_W/4-1, otherwise go to DONE.
REQ-020 SHALL take exactly 5 cycles per word; with the default SPRITE_W, writes occur 5,10,15,20 cycles after acceptance, done is asserted in cycle 21, and req_ready is high in cycle 22.
REQ-021 SHALL assert done for one cycle in DONE, then go to IDLE.
REQ-022 SHALL ignore req_valid while busy; no queuing.
REQ-023 SHALL hold row_we=0 in every state except WRITE.

Reset
REQ-024 SHALL, on Reset_n low, immediately force state IDLE, w=k=0, row_we=0, done=0, busy=0, req_ready=1, sheet_addr=0, row_rd_addr=0, row_wr_addr=0, row_wr_data=0.
REQ-025 SHALL perform no further line-buffer write for the aborted blit after a mid-blit reset; words already written remain.

Configuration
REQ-026 SHALL use macro SPRITE_TRANSPARENCY_EN: when defined, row_rd_addr=(word_x+w) during FETCH, and pixels equal to 0 keep the corresponding nibble of row_rd_data (read-modify-write).
REQ-027 SHALL, when SPRITE_TRANSPARENCY_EN is undefined, write all pixels unconditionally, hold row_rd_addr at 0, and ignore row_rd_data; timing is identical in both builds.

Structure
REQ-028 SHALL take the state enum, PIX_W, SHEET_W (512), TRANSPARENT_IDX (0), and pixels-per-word (4) from shared package sprite_pkg.
REQ-029 SHALL contain one sub-module, pixel_merge, which is combinational: 4 new pixels + old word -> merged word.

Verification
REQ-030 Opaque blit: ROM (y=3, x=10..25)=1..F,1; word_x=0x20 -> writes 0x4321@0x20, 0x8765@0x21, 0xCBA9@0x22, 0x1FED@0x23; done in cycle 21.
REQ-031 Wrap: word_x=0xFE, x=510 -> writes at 0xFE, 0xFF, 0x00, 0x01; sheet x addresses 510, 511, 0, 1.
REQ-032 Transparency (macro on): row word 0xAAAA, pixels 0,5,0,7 -> writes 0x7A5A; macro off -> writes 0x7050.
REQ-033 Busy request: second req_valid during blit -> req_ready=0, no extra writes; the request is accepted in cycle 22.
REQ-034 Reset mid-blit: Reset_n low in cycle 12 -> exactly 2 writes total, done never pulses, req_ready=1 immediately.
REQ-035 Back-to-back: req_valid held high -> two blits, 8 writes, done pulses at cycles 21 and 43.
